// File: rtl/axi_isolate_pkg.sv
// Shared types and helpers for the AXI isolation gate.
package axi_isolate_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    ISOLATED = 2'd2
  } iso_state_e;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Width of a counter able to hold 0..max_cnt inclusive.
  function automatic int cnt_width(input int max_cnt);
    return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/axi_err_slv.sv
// Local DECERR responder used while the downstream region is isolated.
// Serves one transaction at a time; a write wins over a simultaneous read.
module axi_err_slv
  import axi_isolate_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en,
  input  logic                      aw_valid,
  input  logic [AXI_ID_WIDTH-1:0]   aw_id,
  output logic                      aw_ready,
  input  logic                      w_valid,
  input  logic                      w_last,
  output logic                      w_ready,
  output logic                      b_valid,
  output logic [AXI_ID_WIDTH-1:0]   b_id,
  output logic [1:0]                b_resp,
  input  logic                      b_ready,
  input  logic                      ar_valid,
  input  logic [AXI_ID_WIDTH-1:0]   ar_id,
  input  logic [7:0]                ar_len,
  output logic                      ar_ready,
  output logic                      r_valid,
  output logic [AXI_ID_WIDTH-1:0]   r_id,
  output logic [AXI_DATA_WIDTH-1:0] r_data,
  output logic [1:0]                r_resp,
  output logic                      r_last,
  input  logic                      r_ready,
  output logic                      idle
);

  typedef enum logic [1:0] {
    ERR_IDLE  = 2'd0,
    ERR_WDATA = 2'd1,
    ERR_WRESP = 2'd2,
    ERR_RDATA = 2'd3
  } err_state_e;

  err_state_e                state_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [7:0]                len_q;
  logic [7:0]                beat_q;

  // Handshake strobes decode straight from the state register.
  assign idle     = (state_q == ERR_IDLE);
  assign aw_ready = en && idle;
  assign ar_ready = en && idle && !aw_valid;
  assign w_ready  = (state_q == ERR_WDATA);
  assign b_valid  = (state_q == ERR_WRESP);
  assign b_id     = id_q;
  assign b_resp   = RESP_DECERR;
  assign r_valid  = (state_q == ERR_RDATA);
  assign r_id     = id_q;
  assign r_data   = '0;
  assign r_resp   = RESP_DECERR;
  assign r_last   = r_valid && (beat_q == len_q);

  // Responder sequencing: accept, sink or generate beats, release when done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ERR_IDLE;
      beat_q  <= '0;
    end else begin
      case (state_q)
        ERR_IDLE: begin
          beat_q <= '0;
          if (aw_ready && aw_valid) begin
            id_q    <= aw_id;
            state_q <= ERR_WDATA;
          end else if (ar_ready && ar_valid) begin
            id_q    <= ar_id;
            len_q   <= ar_len;
            state_q <= ERR_RDATA;
          end
        end
        ERR_WDATA: if (w_valid && w_last) state_q <= ERR_WRESP;
        ERR_WRESP: if (b_ready) state_q <= ERR_IDLE;
        ERR_RDATA: begin
          if (r_ready) begin
            if (r_last) state_q <= ERR_IDLE;
            else        beat_q  <= beat_q + 8'd1;
          end
        end
        default: state_q <= ERR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axi_isolate_drain.sv
// AXI4 isolation gate: passes traffic in RUN, drains outstanding bursts on
// request, then holds the downstream region isolated until released.
module axi_isolate_drain
  import axi_isolate_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int MAX_WRITE_TXNS = 8,
  parameter int MAX_READ_TXNS  = 8,
  parameter bit ERR_RESP       = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic isolate_req_i,
  output logic isolate_ack_o,
  output logic incoming_req_o,
  output logic busy_o,
  // upstream (slave) port
  input  logic [AXI_ID_WIDTH-1:0] slv_aw_id,  input logic [AXI_ADDR_WIDTH-1:0] slv_aw_addr,
  input  logic [7:0] slv_aw_len, input logic [2:0] slv_aw_size, input logic [1:0] slv_aw_burst,
  input  logic slv_aw_lock, input logic [3:0] slv_aw_cache, input logic [2:0] slv_aw_prot,
  input  logic [3:0] slv_aw_qos, input logic [3:0] slv_aw_region,
  input  logic [AXI_USER_WIDTH-1:0] slv_aw_user,
  input  logic slv_aw_valid, output logic slv_aw_ready,
  input  logic [AXI_DATA_WIDTH-1:0] slv_w_data, input logic [AXI_DATA_WIDTH/8-1:0] slv_w_strb,
  input  logic slv_w_last, input logic [AXI_USER_WIDTH-1:0] slv_w_user,
  input  logic slv_w_valid, output logic slv_w_ready,
  output logic [AXI_ID_WIDTH-1:0] slv_b_id, output logic [1:0] slv_b_resp,
  output logic [AXI_USER_WIDTH-1:0] slv_b_user,
  output logic slv_b_valid, input logic slv_b_ready,
  input  logic [AXI_ID_WIDTH-1:0] slv_ar_id,  input logic [AXI_ADDR_WIDTH-1:0] slv_ar_addr,
  input  logic [7:0] slv_ar_len, input logic [2:0] slv_ar_size, input logic [1:0] slv_ar_burst,
  input  logic slv_ar_lock, input logic [3:0] slv_ar_cache, input logic [2:0] slv_ar_prot,
  input  logic [3:0] slv_ar_qos, input logic [3:0] slv_ar_region,
  input  logic [AXI_USER_WIDTH-1:0] slv_ar_user,
  input  logic slv_ar_valid, output logic slv_ar_ready,
  output logic [AXI_ID_WIDTH-1:0] slv_r_id, output logic [AXI_DATA_WIDTH-1:0] slv_r_data,
  output logic [1:0] slv_r_resp, output logic slv_r_last,
  output logic [AXI_USER_WIDTH-1:0] slv_r_user,
  output logic slv_r_valid, input logic slv_r_ready,
  // downstream (master) port towards the gated region
  output logic [AXI_ID_WIDTH-1:0] mst_aw_id,  output logic [AXI_ADDR_WIDTH-1:0] mst_aw_addr,
  output logic [7:0] mst_aw_len, output logic [2:0] mst_aw_size, output logic [1:0] mst_aw_burst,
  output logic mst_aw_lock, output logic [3:0] mst_aw_cache, output logic [2:0] mst_aw_prot,
  output logic [3:0] mst_aw_qos, output logic [3:0] mst_aw_region,
  output logic [AXI_USER_WIDTH-1:0] mst_aw_user,
  output logic mst_aw_valid, input logic mst_aw_ready,
  output logic [AXI_DATA_WIDTH-1:0] mst_w_data, output logic [AXI_DATA_WIDTH/8-1:0] mst_w_strb,
  output logic mst_w_last, output logic [AXI_USER_WIDTH-1:0] mst_w_user,
  output logic mst_w_valid, input logic mst_w_ready,
  input  logic [AXI_ID_WIDTH-1:0] mst_b_id, input logic [1:0] mst_b_resp,
  input  logic [AXI_USER_WIDTH-1:0] mst_b_user,
  input  logic mst_b_valid, output logic mst_b_ready,
  output logic [AXI_ID_WIDTH-1:0] mst_ar_id,  output logic [AXI_ADDR_WIDTH-1:0] mst_ar_addr,
  output logic [7:0] mst_ar_len, output logic [2:0] mst_ar_size, output logic [1:0] mst_ar_burst,
  output logic mst_ar_lock, output logic [3:0] mst_ar_cache, output logic [2:0] mst_ar_prot,
  output logic [3:0] mst_ar_qos, output logic [3:0] mst_ar_region,
  output logic [AXI_USER_WIDTH-1:0] mst_ar_user,
  output logic mst_ar_valid, input logic mst_ar_ready,
  input  logic [AXI_ID_WIDTH-1:0] mst_r_id, input logic [AXI_DATA_WIDTH-1:0] mst_r_data,
  input  logic [1:0] mst_r_resp, input logic mst_r_last,
  input  logic [AXI_USER_WIDTH-1:0] mst_r_user,
  input  logic mst_r_valid, output logic mst_r_ready
);

  localparam int WCW = cnt_width(MAX_WRITE_TXNS);
  localparam int RCW = cnt_width(MAX_READ_TXNS);
  localparam logic [WCW-1:0] WR_MAX = WCW'(MAX_WRITE_TXNS);
  localparam logic [RCW-1:0] RD_MAX = RCW'(MAX_READ_TXNS);

  // Saturating up/down step; a coincident increment and decrement cancel.
  function automatic int cnt_next(input int cur, input logic inc, input logic dec,
                                  input int max_cnt);
    if (inc && !dec && cur < max_cnt) return cur + 1;
    if (dec && !inc && cur > 0)       return cur - 1;
    return cur;
  endfunction

  iso_state_e     state_q;
  logic           ack_q;
  logic [WCW-1:0] wr_cnt_q, w_pend_q;
  logic [RCW-1:0] rd_cnt_q;

  logic run, iso, wr_full, rd_full;
  logic aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs, drained;

  logic                      err_aw_ready, err_ar_ready, err_w_ready, err_idle;
  logic                      err_b_valid, err_r_valid, err_r_last;
  logic [AXI_ID_WIDTH-1:0]   err_b_id, err_r_id;
  logic [1:0]                err_b_resp, err_r_resp;
  logic [AXI_DATA_WIDTH-1:0] err_r_data;

  assign run     = (state_q == RUN);
  assign iso     = (state_q == ISOLATED);
  assign wr_full = (wr_cnt_q == WR_MAX);
  assign rd_full = (rd_cnt_q == RD_MAX);

  // Payload pass-through, untouched in every state.
  assign mst_aw_id = slv_aw_id;       assign mst_aw_addr = slv_aw_addr;
  assign mst_aw_len = slv_aw_len;     assign mst_aw_size = slv_aw_size;
  assign mst_aw_burst = slv_aw_burst; assign mst_aw_lock = slv_aw_lock;
  assign mst_aw_cache = slv_aw_cache; assign mst_aw_prot = slv_aw_prot;
  assign mst_aw_qos = slv_aw_qos;     assign mst_aw_region = slv_aw_region;
  assign mst_aw_user = slv_aw_user;
  assign mst_ar_id = slv_ar_id;       assign mst_ar_addr = slv_ar_addr;
  assign mst_ar_len = slv_ar_len;     assign mst_ar_size = slv_ar_size;
  assign mst_ar_burst = slv_ar_burst; assign mst_ar_lock = slv_ar_lock;
  assign mst_ar_cache = slv_ar_cache; assign mst_ar_prot = slv_ar_prot;
  assign mst_ar_qos = slv_ar_qos;     assign mst_ar_region = slv_ar_region;
  assign mst_ar_user = slv_ar_user;
  assign mst_w_data = slv_w_data;     assign mst_w_strb = slv_w_strb;
  assign mst_w_last = slv_w_last;     assign mst_w_user = slv_w_user;

  // Address channels only open in RUN and below the outstanding limit.
  assign mst_aw_valid = slv_aw_valid && run && !wr_full;
  assign mst_ar_valid = slv_ar_valid && run && !rd_full;
  assign slv_aw_ready = iso ? err_aw_ready : (mst_aw_ready && run && !wr_full);
  assign slv_ar_ready = iso ? err_ar_ready : (mst_ar_ready && run && !rd_full);

  // Data/response channels keep flowing until isolation, so bursts complete.
  assign mst_w_valid = slv_w_valid && !iso;
  assign slv_w_ready = iso ? err_w_ready : mst_w_ready;

  // While isolated the downstream responses are always sunk.
  assign mst_b_ready = iso || slv_b_ready;
  assign mst_r_ready = iso || slv_r_ready;
  assign slv_b_valid = iso ? err_b_valid : mst_b_valid;
  assign slv_b_id    = iso ? err_b_id    : mst_b_id;
  assign slv_b_resp  = iso ? err_b_resp  : mst_b_resp;
  assign slv_b_user  = iso ? '0          : mst_b_user;
  assign slv_r_valid = iso ? err_r_valid : mst_r_valid;
  assign slv_r_id    = iso ? err_r_id    : mst_r_id;
  assign slv_r_data  = iso ? err_r_data  : mst_r_data;
  assign slv_r_resp  = iso ? err_r_resp  : mst_r_resp;
  assign slv_r_last  = iso ? err_r_last  : mst_r_last;
  assign slv_r_user  = iso ? '0          : mst_r_user;

  assign aw_hs     = mst_aw_valid && mst_aw_ready;
  assign ar_hs     = mst_ar_valid && mst_ar_ready;
  assign w_last_hs = mst_w_valid && mst_w_ready && mst_w_last;
  assign b_hs      = mst_b_valid && mst_b_ready;
  assign r_last_hs = mst_r_valid && mst_r_ready && mst_r_last;

  assign drained = (wr_cnt_q == '0) && (rd_cnt_q == '0) && (w_pend_q == '0)
                   && !aw_hs && !ar_hs;

  assign incoming_req_o = slv_aw_valid || slv_ar_valid;
  assign busy_o         = (wr_cnt_q != '0) || (rd_cnt_q != '0) || (w_pend_q != '0);
  assign isolate_ack_o  = ack_q;

  generate
    if (ERR_RESP) begin : g_err
      axi_err_slv #(
        .AXI_ID_WIDTH   (AXI_ID_WIDTH),
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH)
      ) u_err_slv (
        .clk_i    (clk_i),        .rst_i    (rst_i),        .en       (iso),
        .aw_valid (slv_aw_valid), .aw_id    (slv_aw_id),    .aw_ready (err_aw_ready),
        .w_valid  (slv_w_valid),  .w_last   (slv_w_last),   .w_ready  (err_w_ready),
        .b_valid  (err_b_valid),  .b_id     (err_b_id),     .b_resp   (err_b_resp),
        .b_ready  (slv_b_ready),
        .ar_valid (slv_ar_valid), .ar_id    (slv_ar_id),    .ar_len   (slv_ar_len),
        .ar_ready (err_ar_ready),
        .r_valid  (err_r_valid),  .r_id     (err_r_id),     .r_data   (err_r_data),
        .r_resp   (err_r_resp),   .r_last   (err_r_last),   .r_ready  (slv_r_ready),
        .idle     (err_idle)
      );
    end else begin : g_no_err
      // Isolated traffic is simply back-pressured.
      assign err_aw_ready = 1'b0;
      assign err_ar_ready = 1'b0;
      assign err_w_ready  = 1'b0;
      assign err_b_valid  = 1'b0;
      assign err_b_id     = '0;
      assign err_b_resp   = '0;
      assign err_r_valid  = 1'b0;
      assign err_r_id     = '0;
      assign err_r_data   = '0;
      assign err_r_resp   = '0;
      assign err_r_last   = 1'b0;
      assign err_idle     = 1'b1;
    end
  endgenerate

  // Outstanding-burst bookkeeping for the drain decision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      w_pend_q <= '0;
    end else begin
      wr_cnt_q <= WCW'(cnt_next(int'(wr_cnt_q), aw_hs, b_hs, MAX_WRITE_TXNS));
      rd_cnt_q <= RCW'(cnt_next(int'(rd_cnt_q), ar_hs, r_last_hs, MAX_READ_TXNS));
      w_pend_q <= WCW'(cnt_next(int'(w_pend_q), aw_hs, w_last_hs, MAX_WRITE_TXNS));
    end
  end

  // Isolation FSM; the acknowledge is registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: if (isolate_req_i) state_q <= DRAIN;
        DRAIN: begin
          if (!isolate_req_i) begin
            state_q <= RUN;
          end else if (drained) begin
            state_q <= ISOLATED;
            ack_q   <= 1'b1;
          end
        end
        ISOLATED: begin
          if (!isolate_req_i && err_idle) begin
            state_q <= RUN;
            ack_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= RUN;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  // A response without a matching outstanding request is an integration error.
  a_wr_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(b_hs && !aw_hs && wr_cnt_q == '0));
  a_rd_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(r_last_hs && !ar_hs && rd_cnt_q == '0));
  a_wp_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_last_hs && !aw_hs && w_pend_q == '0));

endmodule
